// File: rtl/cpu_pkg.sv
// Shared definitions for the 24-bit CPU and its boot-time instruction loader.
package cpu_pkg;

  localparam int INSTR_WIDTH  = 24;
  localparam int OPCODE_WIDTH = 4;
  localparam int FUNCT_WIDTH  = 4;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    BYTE0,
    BYTE1,
    BYTE2,
    WRITE,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/instr_loader.sv
// Boot loader: takes a length-prefixed byte stream, packs 24-bit words into
// instruction memory from address 0, then releases the CPU via CpuRun.
//
// state  | meaning
// LEN_HI | waiting for count[15:8]
// LEN_LO | waiting for count[7:0]; range-checks the full count
// BYTE0  | waiting for word[23:16]
// BYTE1  | waiting for word[15:8]
// BYTE2  | waiting for word[7:0]
// WRITE  | one-cycle memory write strobe
// DONE   | load complete, CPU running
// ERROR  | count exceeded memory depth, CPU held
module instr_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic [7:0]             RxData,
  input  logic                   RxValid,
  output logic                   RxReady,
  output logic                   ImemWrEn,
  output logic [ADDR_WIDTH-1:0]  ImemAddr,
  output logic [INSTR_WIDTH-1:0] ImemWrData,
  output logic                   CpuRun,
  output logic                   Busy,
  output logic                   Error
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  loader_state_t          state_q;
  logic [7:0]             len_hi_q;
  logic [16:0]            rem_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_q;
  logic [15:0]            word_q;
  logic [INSTR_WIDTH-1:0] wr_data_q;

  logic        rx_fire;
  logic [15:0] len_full;

  assign rx_fire  = RxValid && RxReady;
  assign len_full = {len_hi_q, RxData};

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q   <= LEN_HI;
      len_hi_q  <= '0;
      rem_q     <= '0;
      addr_q    <= '0;
      wr_addr_q <= '0;
      word_q    <= '0;
      wr_data_q <= '0;
    end else begin
      case (state_q)
        LEN_HI: if (rx_fire) begin
          len_hi_q <= RxData;
          state_q  <= LEN_LO;
        end
        LEN_LO: if (rx_fire) begin
          rem_q <= {1'b0, len_full};
          if (len_full == 16'd0)                state_q <= DONE;
          else if ({16'd0, len_full} > DEPTH)   state_q <= ERROR;
          else                                  state_q <= BYTE0;
        end
        BYTE0: if (rx_fire) begin
          word_q[15:8] <= RxData;
          state_q      <= BYTE1;
        end
        BYTE1: if (rx_fire) begin
          word_q[7:0] <= RxData;
          state_q     <= BYTE2;
        end
        // Output registers load only here so they hold steady outside WRITE.
        BYTE2: if (rx_fire) begin
          wr_data_q <= {word_q, RxData};
          wr_addr_q <= addr_q;
          state_q   <= WRITE;
        end
        WRITE: begin
          addr_q  <= addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          rem_q   <= rem_q - 17'd1;
          state_q <= (rem_q == 17'd1) ? DONE : BYTE0;
        end
        DONE:    state_q <= DONE;
        ERROR:   state_q <= ERROR;
        default: state_q <= LEN_HI;
      endcase
    end
  end

  assign RxReady    = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == BYTE0) ||
                      (state_q == BYTE1)  || (state_q == BYTE2);
  assign ImemWrEn   = (state_q == WRITE);
  assign ImemAddr   = wr_addr_q;
  assign ImemWrData = wr_data_q;
  assign CpuRun     = (state_q == DONE);
  assign Error      = (state_q == ERROR);
  assign Busy       = (state_q != DONE) && (state_q != ERROR);

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: streams built from a word list, expected
// memory writes and CpuRun timing derived from the stream format.
module tb_instr_loader;

  localparam int AW = 8;

  logic          Clock = 1'b0;
  logic          Reset_n = 1'b0;
  logic [7:0]    RxData = '0;
  logic          RxValid = 1'b0;
  logic          RxReady;
  logic          ImemWrEn;
  logic [AW-1:0] ImemAddr;
  logic [23:0]   ImemWrData;
  logic          CpuRun;
  logic          Busy;
  logic          Error;

  instr_loader #(.ADDR_WIDTH(AW)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .RxData(RxData), .RxValid(RxValid),
    .RxReady(RxReady), .ImemWrEn(ImemWrEn), .ImemAddr(ImemAddr),
    .ImemWrData(ImemWrData), .CpuRun(CpuRun), .Busy(Busy), .Error(Error)
  );

  always #5 Clock = ~Clock;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_cnt   = 0;
  logic [31:0] exp_q[$];   // {addr[7:0], data[23:0]}

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge Clock) begin
    if (ImemWrEn === 1'b1) begin
      logic [31:0] e;
      wr_cnt++;
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("write_addr", 32'(ImemAddr), 32'(e[31:24]));
        check("write_data", 32'(ImemWrData), 32'(e[23:0]));
      end
    end
  end

  // Builds the byte stream for the given words and queues the writes a
  // well-behaved loader must produce (none if the count is out of range).
  task automatic build(input int n, input logic [23:0] words[$], output logic [7:0] s[$]);
    s = {};
    s.push_back(8'(n >> 8));
    s.push_back(8'(n));
    foreach (words[i]) begin
      s.push_back(words[i][23:16]);
      s.push_back(words[i][15:8]);
      s.push_back(words[i][7:0]);
      if (n <= (1 << AW)) exp_q.push_back({8'(i % (1 << AW)), words[i]});
    end
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int gap_max, input bit hold_chk,
                             output int first_edge);
    first_edge = -1;
    foreach (s[k]) begin
      int  g;
      bit  acc;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int i = 0; i < g; i++) begin
        @(negedge Clock);
        RxValid = 1'b0;
        RxData  = 8'($urandom);
        if (hold_chk) check("hold_ready", 32'(RxReady), 32'd1);
      end
      @(negedge Clock);
      RxValid = 1'b1;
      RxData  = s[k];
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) begin
        if (t > 0) @(negedge Clock);
        if (RxReady === 1'b1) begin
          if (first_edge < 0) first_edge = cyc;
          acc = 1'b1;
          @(posedge Clock);
        end
      end
      if (!acc) check("accept_timeout", 32'd0, 32'd1);
    end
  endtask

  // Returns the cyc value at the first negedge where the chosen flag is high.
  task automatic wait_flag(input bit use_err, input int bound, output int m);
    m = -1;
    for (int t = 0; t < bound && m < 0; t++) begin
      @(negedge Clock);
      RxValid = 1'b0;
      if ((use_err ? Error : CpuRun) === 1'b1) m = cyc;
    end
    if (m < 0) check(use_err ? "error_timeout" : "run_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rxready"}, 32'(RxReady), 32'd1);
    check({tag, "_wren"},    32'(ImemWrEn), 32'd0);
    check({tag, "_addr"},    32'(ImemAddr), 32'd0);
    check({tag, "_data"},    32'(ImemWrData), 32'd0);
    check({tag, "_cpurun"},  32'(CpuRun), 32'd0);
    check({tag, "_busy"},    32'(Busy), 32'd1);
    check({tag, "_error"},   32'(Error), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset_n = 1'b0;
    RxValid = 1'b0;
    @(negedge Clock);
    exp_q  = {};
    wr_cnt = 0;
    Reset_n = 1'b1;
  endtask

  initial begin
    logic [23:0] w[$];
    logic [7:0]  s[$];
    int e0, m, n;

    @(posedge Clock);
    @(negedge Clock);
    check_reset_vals("init");
    Reset_n = 1'b1;

    // Two words, continuous valid.
    w = {24'h123456, 24'hABCDEF};
    build(2, w, s);
    send_stream(s, 0, 1'b0, e0);
    wait_flag(1'b0, 100, m);
    check("t2_run_cycle", 32'(m - e0), 32'd10);
    check("t2_error", 32'(Error), 32'd0);
    check("t2_writes", 32'(wr_cnt), 32'd2);
    check("t2_rxready", 32'(RxReady), 32'd0);
    check("t2_busy", 32'(Busy), 32'd0);
    check("t2_pending", 32'(exp_q.size()), 32'd0);

    // Empty program.
    do_reset();
    w = {};
    build(0, w, s);
    send_stream(s, 0, 1'b0, e0);
    wait_flag(1'b0, 100, m);
    check("t3_run_cycle", 32'(m - e0), 32'd2);
    check("t3_writes", 32'(wr_cnt), 32'd0);
    check("t3_rxready", 32'(RxReady), 32'd0);

    // Count 257 > depth.
    do_reset();
    s = {8'h01, 8'h01};
    send_stream(s, 0, 1'b0, e0);
    wait_flag(1'b1, 100, m);
    check("t4_err_cycle", 32'(m - e0), 32'd2);
    repeat (5) @(negedge Clock);
    check("t4_error", 32'(Error), 32'd1);
    check("t4_cpurun", 32'(CpuRun), 32'd0);
    check("t4_rxready", 32'(RxReady), 32'd0);
    check("t4_writes", 32'(wr_cnt), 32'd0);

    // Full-depth program of random words.
    do_reset();
    w = {};
    for (int i = 0; i < 256; i++) w.push_back(24'($urandom));
    build(256, w, s);
    send_stream(s, 0, 1'b0, e0);
    wait_flag(1'b0, 100, m);
    check("t5_run_cycle", 32'(m - e0), 32'(2 + 4 * 256));
    check("t5_writes", 32'(wr_cnt), 32'd256);
    check("t5_last_addr", 32'(ImemAddr), 32'hFF);
    check("t5_error", 32'(Error), 32'd0);
    check("t5_pending", 32'(exp_q.size()), 32'd0);

    // Single word with random valid gaps; no write before the third byte lands.
    do_reset();
    w = {24'h000F00};
    build(1, w, s);
    s.pop_back();
    send_stream(s, 5, 1'b1, e0);
    check("t6_no_early_write", 32'(wr_cnt), 32'd0);
    s = {8'h00};
    send_stream(s, 5, 1'b1, e0);
    @(negedge Clock);
    RxValid = 1'b0;
    check("t6_wren_next", 32'(ImemWrEn), 32'd1);
    wait_flag(1'b0, 100, m);
    check("t6_writes", 32'(wr_cnt), 32'd1);
    check("t6_pending", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of the third instruction.
    do_reset();
    w = {24'hAABBCC, 24'hDDEEFF};
    build(3, w, s);
    s[0] = 8'h00; s[1] = 8'h03;
    s.push_back(8'h01);
    s.push_back(8'h02);
    send_stream(s, 0, 1'b0, e0);
    @(negedge Clock);
    Reset_n = 1'b0;
    RxValid = 1'b0;
    @(negedge Clock);
    check_reset_vals("t7");
    check("t7_writes", 32'(wr_cnt), 32'd2);
    check("t7_pending", 32'(exp_q.size()), 32'd0);
    Reset_n = 1'b1;
    wr_cnt = 0;
    w = {24'h112233};
    build(1, w, s);
    send_stream(s, 0, 1'b0, e0);
    wait_flag(1'b0, 100, m);
    check("t7_run_cycle", 32'(m - e0), 32'd6);
    check("t7_fresh_writes", 32'(wr_cnt), 32'd1);
    check("t7_fresh_pending", 32'(exp_q.size()), 32'd0);

    // Bytes offered after DONE are ignored.
    n = wr_cnt;
    repeat (10) begin
      @(negedge Clock);
      RxValid = 1'b1;
      RxData  = 8'($urandom);
    end
    @(negedge Clock);
    RxValid = 1'b0;
    check("t8_rxready", 32'(RxReady), 32'd0);
    check("t8_writes", 32'(wr_cnt), 32'(n));
    check("t8_cpurun", 32'(CpuRun), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time instruction loader placed directly upstream of the 24-bit single-cycle CPU. It receives a byte stream over a valid/ready handshake, assembles 24-bit instruction words and writes them sequentially into the CPU's instruction memory from address 0. When the programmed count has been written, it releases the CPU by asserting `CpuRun`; until then the CPU is held idle.

## Interface
- `ADDR_WIDTH`, 8, instruction-memory address width; depth = 2^ADDR_WIDTH words
- `Clock`  in  1  single system clock, all logic on rising edge
- `Reset_n`  in  1  synchronous, active-low reset
- `RxData`  in  8  incoming byte
- `RxValid`  in  1  `RxData` valid
- `RxReady`  out  1  loader can accept a byte; transfer occurs when `RxValid && RxReady` at a rising edge
- `ImemWrEn`  out  1  one-cycle write strobe to instruction memory
- `ImemAddr`  out  ADDR_WIDTH  write address
- `ImemWrData`  out  24  assembled instruction word
- `CpuRun`  out  1  high once loading is complete; CPU clock-enable / run gate
- `Busy`  out  1  high while loading is in progress (any state other than DONE/ERROR)
- `Error`  out  1  sticky; length header exceeds memory depth

## Operation
- Stream format: 2-byte count N (big-endian, 16 bit), then N instructions of 3 bytes each, big-endian (first byte = bits 23:16, holds opcode in 23:20).
- FSM states: LEN_HI, LEN_LO, BYTE0, BYTE1, BYTE2, WRITE, DONE, ERROR.
- LEN_HI: accept byte -> count[15:8], go LEN_LO.
- LEN_LO: accept byte -> count[7:0]; if full count == 0 -> DONE; if count > 2^ADDR_WIDTH -> ERROR; else -> BYTE0.
- BYTE0/1/2: accept byte into word[23:16]/[15:8]/[7:0]; advance on each accept, BYTE2 -> WRITE.
- WRITE: `ImemWrEn`=1 for exactly one cycle with current `ImemAddr` and word; then address +1, remaining -1; remaining reaches 0 -> DONE, else -> BYTE0.
- DONE: `CpuRun`=1, `RxReady`=0, stays until reset. Extra bytes are never accepted.
- ERROR: `Error`=1, `CpuRun`=0, `RxReady`=0, stays until reset. No memory writes ever occur on error.
- `RxReady`=1 only in LEN_HI, LEN_LO, BYTE0, BYTE1, BYTE2. `RxValid` low stalls the FSM in place indefinitely; no timeout.
- Remaining counter is 17 bits wide so N = 2^ADDR_WIDTH is legal; address wraps to 0 after the last write (unused).
- `ImemWrData` and `ImemAddr` hold their last value outside WRITE.

## Timing
- Reset (`Reset_n` low at an edge): state LEN_HI, address 0, count 0, word 0. Values after reset: `RxReady`=1, `ImemWrEn`=0, `ImemAddr`=0, `ImemWrData`=0, `CpuRun`=0, `Busy`=1, `Error`=0.
- Reset mid-load aborts immediately; partial words are discarded. Already-written memory contents are not cleared.
- Third byte accepted at edge k -> `ImemWrEn` high during cycle k+1.
- Continuous `RxValid`: first accept at cycle 0 -> `CpuRun` high from cycle 2+4N. N=0 -> `CpuRun` at cycle 2.
- Throughput: one instruction per 4 cycles maximum (3 accept + 1 write).
- All outputs are decoded from registered state only; no combinational path from `RxValid` to `RxReady`.

## Structure
- Shared package `cpu_pkg`: `INSTR_WIDTH`=24, `OPCODE_WIDTH`=4, `FUNCT_WIDTH`=4, loader state enum `loader_state_t`.
- Single module; no sub-module. Byte assembly, counters and FSM live in `instr_loader`.

## Test plan
- Stream 00 02 | 12 34 56 | AB CD EF, `RxValid` held high -> writes 0x123456 @0, 0xABCDEF @1; `CpuRun` rises at cycle 10; `Error`=0.
- Stream 00 00 -> no write strobes; `CpuRun`=1 at cycle 2; `RxReady`=0 thereafter.
- ADDR_WIDTH=8, stream 01 01 -> ERROR after second byte; `Error`=1, `CpuRun`=0, zero writes; N=0x0100 with 256 words -> all written, last at 0xFF, `CpuRun`=1.
- N=1 with `RxValid` toggled randomly (gaps of 0-5 cycles) -> single write 0x000F00 @0 only after third accept; FSM holds during gaps.
- Assert `Reset_n` low after byte BYTE1 of instruction 2 -> outputs return to reset values; fresh stream 00 01 | 11 22 33 writes 0x112233 @0.
- Bytes sent after DONE -> `RxReady` stays 0, no additional writes, `CpuRun` stays 1.
